calcn_dispatch_engine: RTL

Parametrised N-port successor to the calc2 datapath. Each port submits two-beat commands (cmd+operand1, then operand2) with a tag. Commands are captured into a per-port in-order queue, arbitrated round-robin onto one shared single-cycle ALU, and answered on the originating port's output bus. Adds per-port backpressure (req_ready) and a sticky drop flag, which calc2 lacks.

---
 rtl/calcn_pkg.sv | 36 +++
 rtl/calcn_req_queue.sv | 128 ++++++++++++
 rtl/calcn_dispatch_engine.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/calcn_pkg.sv
// Shared types for the N-port calculator dispatch engine: command/response
// encodings, the default queue entry layout and the shift-amount width helper.
package calcn_pkg;

    localparam int CMD_W      = 4;
    localparam int RESP_W     = 2;
    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    // cmd is kept as raw bits so invalid codes survive to the ALU.
    typedef struct packed {
        logic [CMD_W-1:0]      cmd;
        logic [DATA_W_DEF-1:0] op1;
        logic [DATA_W_DEF-1:0] op2;
        logic [TAG_W_DEF-1:0]  tag;
    } entry_t;

    function automatic int shamt_w(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/calcn_req_queue.sv
// One request port: two-beat capture FSM feeding an in-order DEPTH-entry FIFO.
//   state    | meaning
//   CAP_IDLE | waiting for a nonzero command (op1 and tag arrive with it)
//   CAP_OP2  | command latched; this cycle's data is op2, entry is enqueued
module calcn_req_queue
    import calcn_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CMD_W-1:0]  cmd_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              req_ready,
    output logic              drop_err,
    input  logic              pop,
    output logic              head_valid,
    output logic [CMD_W-1:0]  head_cmd,
    output logic [DATA_W-1:0] head_op1,
    output logic [DATA_W-1:0] head_op2,
    output logic [TAG_W-1:0]  head_tag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [TAG_W-1:0]  tag;
    } q_entry_t;

    typedef enum logic {CAP_IDLE, CAP_OP2} cap_state_e;

    cap_state_e        state_q, state_d;
    logic [CMD_W-1:0]  cmd_hold_q, cmd_hold_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d, pending;
    logic              drop_q, drop_d;
    logic              push, do_pop;
    q_entry_t          mem_q [DEPTH];
    q_entry_t          new_entry;

    always_comb begin
        state_d    = state_q;
        cmd_hold_d = cmd_hold_q;
        op1_d      = op1_q;
        tag_d      = tag_q;
        drop_d     = drop_q;
        push       = 1'b0;
        // Ready counts the in-flight OP2 beat so a capture never lands on a full FIFO.
        pending    = count_q + CNT_W'(state_q == CAP_OP2);
        req_ready  = (pending < CNT_W'(DEPTH));
        case (state_q)
            CAP_IDLE: begin
                if (cmd_in != '0) begin
                    if (req_ready) begin
                        state_d    = CAP_OP2;
                        cmd_hold_d = cmd_in;
                        op1_d      = data_in;
                        tag_d      = tag_in;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            CAP_OP2: begin
                push    = (count_q < CNT_W'(DEPTH));
                state_d = CAP_IDLE;
            end
            default: state_d = CAP_IDLE;
        endcase

        do_pop   = pop && (count_q != '0);
        wr_ptr_d = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && do_pop) begin
            count_d = count_q - 1'b1;
        end

        new_entry = '{cmd: cmd_hold_q, op1: op1_q, op2: data_in, tag: tag_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CAP_IDLE;
            cmd_hold_q <= '0;
            op1_q      <= '0;
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_hold_q <= cmd_hold_d;
            op1_q      <= op1_d;
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    assign drop_err   = drop_q;
    assign head_valid = (count_q != '0);
    assign head_cmd   = mem_q[rd_ptr_q].cmd;
    assign head_op1   = mem_q[rd_ptr_q].op1;
    assign head_op2   = mem_q[rd_ptr_q].op2;
    assign head_tag   = mem_q[rd_ptr_q].tag;

endmodule

// File: rtl/calcn_dispatch_engine.sv
// N-port command dispatcher: per-port capture queues, round-robin grant onto
// one shared single-cycle ALU, registered one-cycle response per grant.
module calcn_dispatch_engine
    import calcn_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 2,
    parameter int DEPTH   = 4
) (
    input  logic                        a_clk,
    input  logic                        reset,
    input  logic [N_PORTS*CMD_W-1:0]    req_cmd_in,
    input  logic [N_PORTS*DATA_W-1:0]   req_data_in,
    input  logic [N_PORTS*TAG_W-1:0]    req_tag_in,
    output logic [N_PORTS-1:0]          req_ready,
    output logic [N_PORTS*RESP_W-1:0]   out_resp,
    output logic [N_PORTS*DATA_W-1:0]   out_data,
    output logic [N_PORTS*TAG_W-1:0]    out_tag,
    output logic [N_PORTS-1:0]          drop_err
);

    localparam int PW = $clog2(N_PORTS);
    localparam int SW = shamt_w(DATA_W);

    logic [N_PORTS-1:0]              head_valid, pop;
    logic [N_PORTS-1:0][CMD_W-1:0]   head_cmd;
    logic [N_PORTS-1:0][DATA_W-1:0]  head_op1, head_op2;
    logic [N_PORTS-1:0][TAG_W-1:0]   head_tag;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        calcn_req_queue #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W),
            .DEPTH  (DEPTH)
        ) u_queue (
            .clk        (a_clk),
            .rst        (reset),
            .cmd_in     (req_cmd_in[p*CMD_W +: CMD_W]),
            .data_in    (req_data_in[p*DATA_W +: DATA_W]),
            .tag_in     (req_tag_in[p*TAG_W +: TAG_W]),
            .req_ready  (req_ready[p]),
            .drop_err   (drop_err[p]),
            .pop        (pop[p]),
            .head_valid (head_valid[p]),
            .head_cmd   (head_cmd[p]),
            .head_op1   (head_op1[p]),
            .head_op2   (head_op2[p]),
            .head_tag   (head_tag[p])
        );
    end

    logic [PW-1:0]                   rr_ptr_q, rr_ptr_d, grant_idx, cand;
    logic                            grant_vld;
    logic [CMD_W-1:0]                sel_cmd;
    logic [DATA_W-1:0]               sel_op1, sel_op2, alu_data;
    logic [TAG_W-1:0]                sel_tag;
    logic [DATA_W:0]                 sum;
    resp_e                           alu_resp;
    logic [N_PORTS-1:0][RESP_W-1:0]  out_resp_q, out_resp_d;
    logic [N_PORTS-1:0][DATA_W-1:0]  out_data_q, out_data_d;
    logic [N_PORTS-1:0][TAG_W-1:0]   out_tag_q, out_tag_d;

    // Search starts one past the last winner, so a busy port yields to every other busy port.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        cand      = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            cand = PW'((int'(rr_ptr_q) + i) % N_PORTS);
            if (!grant_vld && head_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        pop = '0;
        if (grant_vld) begin
            pop[grant_idx] = 1'b1;
        end
        rr_ptr_d = grant_vld ? grant_idx : rr_ptr_q;
    end

    always_comb begin
        sel_cmd  = head_cmd[grant_idx];
        sel_op1  = head_op1[grant_idx];
        sel_op2  = head_op2[grant_idx];
        sel_tag  = head_tag[grant_idx];
        sum      = {1'b0, sel_op1} + {1'b0, sel_op2};
        alu_resp = RESP_ERR;
        alu_data = '0;
        case (sel_cmd)
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    alu_resp = RESP_OK;
                    alu_data = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (sel_op2 <= sel_op1) begin
                    alu_resp = RESP_OK;
                    alu_data = sel_op1 - sel_op2;
                end
            end
            CMD_SHL: begin
                alu_resp = RESP_OK;
                alu_data = sel_op1 << sel_op2[SW-1:0];
            end
            CMD_SHR: begin
                alu_resp = RESP_OK;
                alu_data = sel_op1 >> sel_op2[SW-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        out_resp_d = '0;
        out_data_d = '0;
        out_tag_d  = '0;
        if (grant_vld) begin
            out_resp_d[grant_idx] = alu_resp;
            out_data_d[grant_idx] = alu_data;
            out_tag_d[grant_idx]  = sel_tag;
        end
    end

    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= PW'(N_PORTS - 1);
            out_resp_q <= '0;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            out_resp_q <= out_resp_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
        end
    end

    assign out_resp = out_resp_q;
    assign out_data = out_data_q;
    assign out_tag  = out_tag_q;

endmodule
